// File: rtl/lpdecim.sv
// lpdecim: rescales 32-bit FIR accumulator samples to saturated Q15, keeps 1 of C_DECIM,
// and buffers kept samples in a small FIFO. Optional saturation counter: LPDECIM_SAT_CNT_EN.
module lpdecim #(
  parameter int C_SHIFT = 15,
  parameter int C_DECIM = 4,
  parameter int C_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_prdy,
  output logic        c_crdy,
  output logic        c_cerr,
  input  logic [31:0] c_data,
  output logic        p_prdy,
  input  logic        p_crdy,
  input  logic        p_cerr,
  output logic [31:0] p_data,
  input  logic        rc_reqn,
`ifdef LPDECIM_SAT_CNT_EN
  output logic [15:0] sat_cnt,
`endif
  output logic        rc_ackn
);

  localparam int AW = $clog2(C_DEPTH);
  localparam int DW = (C_DECIM > 1) ? $clog2(C_DECIM) : 1;
  localparam logic [DW-1:0] DMAX = DW'(C_DECIM - 1);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

  localparam logic signed [32:0] RND  = 33'sd1 <<< (C_SHIFT - 1);
  localparam logic signed [32:0] QMAX = 33'sd32767;
  localparam logic signed [32:0] QMIN = -33'sd32768;

  // Handshakes: a transfer happens on a rising edge where the producer's valid
  // (c_prdy / p_prdy) and the consumer's ready (c_crdy / p_crdy) are both high;
  // p_cerr acts like p_crdy but the popped sample is discarded.

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [AW:0]   wr_q, rd_q;
  logic          rc_ackn_q;
  logic [15:0]   mem [C_DEPTH];

  logic                 empty, full, accept, keep, push, pop, sat;
  logic signed [32:0]   sum_s, shr_s;
  logic [15:0]          q15, head;

  // 33-bit sum so the rounding constant can never overflow the input range.
  assign sum_s = $signed({c_data[31], c_data}) + RND;
  assign shr_s = sum_s >>> C_SHIFT;
  assign sat   = (shr_s > QMAX) || (shr_s < QMIN);
  assign q15   = (shr_s > QMAX) ? 16'h7FFF :
                 (shr_s < QMIN) ? 16'h8000 : shr_s[15:0];

  assign empty  = (wr_q == rd_q);
  assign full   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign keep   = (dcnt_q == '0);
  // Discarded samples are still taken while full, so upstream never stalls on them.
  assign c_crdy = ~rst & (state_q == ST_RUN) & (~full | ~keep);
  assign c_cerr = (state_q != ST_RUN);
  assign accept = c_prdy & c_crdy;
  assign push   = accept & keep;
  assign p_prdy = ~empty;
  assign pop    = p_prdy & (p_crdy | p_cerr);
  assign head   = mem[rd_q[AW-1:0]];
  assign p_data = empty ? 32'h0 : {{16{head[15]}}, head};
  assign rc_ackn = rc_ackn_q;

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    if (accept) dcnt_d = (dcnt_q == DMAX) ? '0 : dcnt_q + DW'(1);
    case (state_q)
      ST_RUN:   if (!rc_reqn) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (rc_reqn)    state_d = ST_RUN;
        else if (empty) state_d = ST_ACK;
      end
      ST_ACK: begin
        if (rc_reqn) begin
          state_d = ST_RUN;
          dcnt_d  = '0;
        end
      end
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      dcnt_q    <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      rc_ackn_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      rc_ackn_q <= (state_d != ST_ACK);
      if (push) wr_q <= wr_q + (AW+1)'(1);
      if (pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q[AW-1:0]] <= q15;
  end

`ifdef LPDECIM_SAT_CNT_EN
  logic [15:0] sat_cnt_q;
  assign sat_cnt = sat_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt_q <= '0;
    end else if ((state_q == ST_ACK) && rc_reqn) begin
      sat_cnt_q <= '0;
    end else if (push && sat && (sat_cnt_q != 16'hFFFF)) begin
      sat_cnt_q <= sat_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lpdecim.sv
// Directed bench for lpdecim: one instance with C_DECIM=4, one with C_DECIM=1.
// Inputs are driven and outputs checked on the falling clock edge.
module tb_lpdecim;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        c_prdy4, c_crdy4, c_cerr4, p_prdy4, p_crdy4, p_cerr4, rc_reqn4, rc_ackn4;
  logic [31:0] c_data4, p_data4;
  logic        c_prdy1, c_crdy1, c_cerr1, p_prdy1, p_crdy1, p_cerr1, rc_reqn1, rc_ackn1;
  logic [31:0] c_data1, p_data1;
`ifdef LPDECIM_SAT_CNT_EN
  logic [15:0] sat_cnt4, sat_cnt1;
`endif

  lpdecim #(.C_SHIFT(15), .C_DECIM(4), .C_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .c_prdy(c_prdy4), .c_crdy(c_crdy4), .c_cerr(c_cerr4),
    .c_data(c_data4), .p_prdy(p_prdy4), .p_crdy(p_crdy4), .p_cerr(p_cerr4),
    .p_data(p_data4), .rc_reqn(rc_reqn4),
`ifdef LPDECIM_SAT_CNT_EN
    .sat_cnt(sat_cnt4),
`endif
    .rc_ackn(rc_ackn4));

  lpdecim #(.C_SHIFT(15), .C_DECIM(1), .C_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .c_prdy(c_prdy1), .c_crdy(c_crdy1), .c_cerr(c_cerr1),
    .c_data(c_data1), .p_prdy(p_prdy1), .p_crdy(p_crdy1), .p_cerr(p_cerr1),
    .p_data(p_data1), .rc_reqn(rc_reqn1),
`ifdef LPDECIM_SAT_CNT_EN
    .sat_cnt(sat_cnt1),
`endif
    .rc_ackn(rc_ackn1));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
    logic        sat;
  } vec_t;

  vec_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] smp(input int v);
    return 32'(v * 32768);
  endfunction

  initial begin
    int nsat;
    tbl[0] = '{32'd16384,      32'h0000_0001, 1'b0};
    tbl[1] = '{32'd16383,      32'h0000_0000, 1'b0};
    tbl[2] = '{32'hFFFF_BFFF,  32'hFFFF_FFFF, 1'b0};
    tbl[3] = '{32'h7FFF_FFFF,  32'h0000_7FFF, 1'b1};
    tbl[4] = '{32'h8000_0000,  32'hFFFF_8000, 1'b1};
    tbl[5] = '{32'h3FFF_8000,  32'h0000_7FFF, 1'b0};
    tbl[6] = '{32'hC000_0000,  32'hFFFF_8000, 1'b0};
    tbl[7] = '{32'h3FFF_C000,  32'h0000_7FFF, 1'b1};
    tbl[8] = '{32'hBFFF_BFFF,  32'hFFFF_8000, 1'b1};

    c_prdy4 = 0; c_data4 = 0; p_crdy4 = 0; p_cerr4 = 0; rc_reqn4 = 1;
    c_prdy1 = 0; c_data1 = 0; p_crdy1 = 0; p_cerr1 = 0; rc_reqn1 = 1;

    // Reset values while rst is held
    repeat (2) @(negedge clk);
    check("rst_c_crdy", {31'd0, c_crdy1}, 32'd0);
    check("rst_c_cerr", {31'd0, c_cerr1}, 32'd0);
    check("rst_p_prdy", {31'd0, p_prdy1}, 32'd0);
    check("rst_p_data", p_data1, 32'd0);
    check("rst_rc_ackn", {31'd0, rc_ackn4}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("run_c_crdy", {31'd0, c_crdy4}, 32'd1);

    // Decimate-by-4 stream: only k = 0, 4, 8 emerge, one cycle after acceptance
    p_crdy4 = 1;
    for (int k = 0; k < 12; k++) begin
      c_prdy4 = 1; c_data4 = smp(k);
      check("dec_c_crdy", {31'd0, c_crdy4}, 32'd1);
      cyc();
      check("dec_p_prdy", {31'd0, p_prdy4}, (k % 4 == 0) ? 32'd1 : 32'd0);
      if (k % 4 == 0) check("dec_p_data", p_data4, 32'(k));
    end
    c_prdy4 = 0;

    // Rounding / saturation table on the C_DECIM=1 instance
    p_crdy1 = 1;
    nsat = 0;
    for (int i = 0; i < 9; i++) begin
      c_prdy1 = 1; c_data1 = tbl[i].din;
      check("rnd_c_crdy", {31'd0, c_crdy1}, 32'd1);
      cyc();
      c_prdy1 = 0;
      if (tbl[i].sat) nsat++;
      check("rnd_p_prdy", {31'd0, p_prdy1}, 32'd1);
      check("rnd_p_data", p_data1, tbl[i].dout);
      cyc();
    end
    check("rnd_empty", {31'd0, p_prdy1}, 32'd0);
`ifdef LPDECIM_SAT_CNT_EN
    check("rnd_sat_cnt", {16'd0, sat_cnt1}, 32'(nsat));
`endif

    // Backpressure: fill, then concurrent push/pop with order preserved
    p_crdy1 = 0;
    for (int i = 0; i < 4; i++) begin
      c_prdy1 = 1; c_data1 = smp(10 + i);
      check("bp_c_crdy", {31'd0, c_crdy1}, 32'd1);
      cyc();
    end
    check("bp_full", {31'd0, c_crdy1}, 32'd0);
    check("bp_head", p_data1, 32'd10);
    c_data1 = smp(14); p_crdy1 = 1;
    cyc();
    check("bp_pop1", p_data1, 32'd11);
    check("bp_crdy_again", {31'd0, c_crdy1}, 32'd1);
    cyc();
    check("bp_pp1", p_data1, 32'd12);
    c_data1 = smp(15);
    cyc();
    check("bp_pp2", p_data1, 32'd13);
    c_prdy1 = 0;
    cyc();
    check("bp_tail1", p_data1, 32'd14);
    cyc();
    check("bp_tail2", p_data1, 32'd15);
    cyc();
    check("bp_empty", {31'd0, p_prdy1}, 32'd0);

    // p_cerr drops the head while a new sample is pushed in the same cycle
    p_crdy1 = 0;
    for (int i = 0; i < 2; i++) begin
      c_prdy1 = 1; c_data1 = smp(20 + i);
      cyc();
    end
    check("cerr_head", p_data1, 32'd20);
    c_data1 = smp(22); p_cerr1 = 1;
    cyc();
    c_prdy1 = 0; p_cerr1 = 0;
    check("cerr_next", p_data1, 32'd21);
    check("cerr_prdy", {31'd0, p_prdy1}, 32'd1);
    p_crdy1 = 1;
    cyc();
    check("cerr_kept", p_data1, 32'd22);
    cyc();
    check("cerr_empty", {31'd0, p_prdy1}, 32'd0);

    // Reconfiguration drain on the C_DECIM=4 instance (3 kept entries, dcnt=1)
    p_crdy4 = 0;
    for (int k = 40; k < 49; k++) begin
      c_prdy4 = 1; c_data4 = smp(k);
      cyc();
    end
    c_prdy4 = 0;
    check("rc_head", p_data4, 32'd40);
    rc_reqn4 = 0;
    cyc();
    check("rc_drain_crdy", {31'd0, c_crdy4}, 32'd0);
    check("rc_drain_cerr", {31'd0, c_cerr4}, 32'd1);
    check("rc_drain_ackn", {31'd0, rc_ackn4}, 32'd1);
    c_prdy4 = 1; c_data4 = smp(99); p_crdy4 = 1;
    cyc();
    check("rc_d1", p_data4, 32'd44);
    cyc();
    check("rc_d2", p_data4, 32'd48);
    cyc();
    check("rc_d3_empty", {31'd0, p_prdy4}, 32'd0);
    check("rc_d3_ackn", {31'd0, rc_ackn4}, 32'd1);
    cyc();
    check("rc_ack", {31'd0, rc_ackn4}, 32'd0);
    check("rc_ack_cerr", {31'd0, c_cerr4}, 32'd1);
    check("rc_ack_crdy", {31'd0, c_crdy4}, 32'd0);
    cyc();
    check("rc_ack_hold", {31'd0, rc_ackn4}, 32'd0);
    check("rc_ack_noout", {31'd0, p_prdy4}, 32'd0);
    rc_reqn4 = 1; c_prdy4 = 0;
    cyc();
    check("rc_rel_ackn", {31'd0, rc_ackn4}, 32'd1);
    check("rc_rel_cerr", {31'd0, c_cerr4}, 32'd0);
    check("rc_rel_crdy", {31'd0, c_crdy4}, 32'd1);
    c_prdy4 = 1; c_data4 = smp(50);
    cyc();
    check("rc_kept_prdy", {31'd0, p_prdy4}, 32'd1);
    check("rc_kept_data", p_data4, 32'd50);
    c_data4 = smp(51);
    cyc();
    c_prdy4 = 0;
    check("rc_next_drop", {31'd0, p_prdy4}, 32'd0);

    // Asynchronous reset with the FIFO half full
    p_crdy1 = 0;
    for (int i = 0; i < 2; i++) begin
      c_prdy1 = 1; c_data1 = smp(70 + i);
      cyc();
    end
    c_prdy1 = 0;
    check("ar_before", {31'd0, p_prdy1}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_p_prdy", {31'd0, p_prdy1}, 32'd0);
    check("ar_p_data", p_data1, 32'd0);
    check("ar_c_crdy", {31'd0, c_crdy1}, 32'd0);
`ifdef LPDECIM_SAT_CNT_EN
    check("ar_sat_cnt", {16'd0, sat_cnt1}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    c_prdy1 = 1; c_data1 = smp(80); p_crdy1 = 1;
    cyc();
    c_prdy1 = 0;
    check("ar_first_prdy", {31'd0, p_prdy1}, 32'd1);
    check("ar_first_data", p_data1, 32'd80);
    cyc();
    check("ar_empty", {31'd0, p_prdy1}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
